// File: rtl/mem_pkg.sv
// Shared types for the memory stage: FSM state, counter sizing and pipeline-register control fields.
// No logic of its own; data fields stay as plain N-wide vectors next to these structs.
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_e;

   // Wait counter must be able to hold the value TIMEOUT itself.
   function automatic int cnt_width(input int timeout);
      return $clog2(timeout + 1);
   endfunction

   typedef struct packed {
      logic       valid;
      logic       branch;
      logic       mem_read;
      logic       mem_write;
      logic       reg_write;
      logic       mem_to_reg;
      logic       zero;
      logic [4:0] rd;
   } m_ctrl_t;

   typedef struct packed {
      logic       valid;
      logic       reg_write;
      logic       mem_to_reg;
      logic       err;
      logic [4:0] rd;
   } w_ctrl_t;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/ack bundle between the memory stage (master) and the data memory (slave).
// Request fields hold steady while dm_req is high; dm_rdata is meaningful only with dm_ack.
interface mem_stage_if #(parameter int N = 64);

   logic         dm_req;
   logic         dm_we;
   logic [N-1:0] dm_addr;
   logic [N-1:0] dm_wdata;
   logic         dm_ack;
   logic [N-1:0] dm_rdata;

   modport master (output dm_req, dm_we, dm_addr, dm_wdata, input dm_ack, dm_rdata);
   modport slave  (input dm_req, dm_we, dm_addr, dm_wdata, output dm_ack, dm_rdata);

endinterface

// File: rtl/mem_stage_flopenr.sv
// Enabled register with synchronous active-low clear; one edge of latency, holds while en is low.
module flopenr #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (!reset)  q <= '0;
      else if (en) q <= d;
   end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: EX/MEM register, CBZ resolve, data-memory req/ack with timeout, MEM/WB register.
// E to W in 2 edges; an outstanding access stalls upstream and sends bubbles to W.
module mem_stage
   import mem_pkg::*;
#(
   parameter int N       = 64,
   parameter int TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             valid_E,
   input  logic [N-1:0]     PCBranch_E,
   input  logic [N-1:0]     aluResult_E,
   input  logic [N-1:0]     writeData_E,
   input  logic             zero_E,
   input  logic             Branch_E,
   input  logic             MemRead_E,
   input  logic             MemWrite_E,
   input  logic             RegWrite_E,
   input  logic             MemtoReg_E,
   input  logic [4:0]       rd_E,
   output logic             stall_M,
   output logic             PCSrc_M,
   output logic [N-1:0]     PCBranch_M,
   mem_stage_if.master      dm,
   output logic             valid_W,
   output logic             RegWrite_W,
   output logic             MemtoReg_W,
   output logic             err_W,
   output logic [N-1:0]     aluResult_W,
   output logic [N-1:0]     readData_W,
   output logic [4:0]       rd_W
);

   localparam int               CNT_W  = cnt_width(TIMEOUT);
   localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);
   localparam int               MW     = $bits(m_ctrl_t) + 3 * N;
   localparam int               WW     = $bits(w_ctrl_t) + 2 * N;

   m_ctrl_t          ctrl_e, ctrl_m;
   w_ctrl_t          ctrl_w_d, ctrl_w;
   logic [MW-1:0]    m_d, m_q;
   logic [WW-1:0]    w_d, w_q;
   logic [N-1:0]     alu_result_m, write_data_m, read_data_d;
   state_e           state_d, state_q;
   logic [CNT_W-1:0] cnt_d, cnt_q;
   logic             memop_m, req, timeout_hit, stall;

   // EX/MEM register; a taken branch squashes the instruction entering behind it.
   always_comb begin
      ctrl_e            = '0;
      ctrl_e.valid      = valid_E & ~PCSrc_M;
      ctrl_e.branch     = Branch_E;
      ctrl_e.mem_read   = MemRead_E;
      ctrl_e.mem_write  = MemWrite_E;
      ctrl_e.reg_write  = RegWrite_E;
      ctrl_e.mem_to_reg = MemtoReg_E;
      ctrl_e.zero       = zero_E;
      ctrl_e.rd         = rd_E;
      m_d               = {ctrl_e, PCBranch_E, aluResult_E, writeData_E};
   end

   flopenr #(.W(MW)) u_m_reg (
      .clk   (clk),
      .reset (reset),
      .en    (~stall),
      .d     (m_d),
      .q     (m_q)
   );

   assign {ctrl_m, PCBranch_M, alu_result_m, write_data_m} = m_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // DONE is never entered; it falls into the IDLE branch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         WAIT: begin
            if (dm.dm_ack || timeout_hit) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            if (req && !dm.dm_ack) begin
               state_d = WAIT;
               cnt_d   = CNT_W'(1);
            end
         end
      endcase
   end

   // Request is combinational so a same-cycle ack costs no stall.
   always_comb begin
      memop_m     = ctrl_m.valid & (ctrl_m.mem_read | ctrl_m.mem_write);
      req         = memop_m & (state_q != DONE);
      timeout_hit = (state_q == WAIT) & (cnt_q == TO_CNT) & ~dm.dm_ack;
      stall       = req & ~dm.dm_ack & ~timeout_hit;
      PCSrc_M     = ctrl_m.valid & ctrl_m.branch & ctrl_m.zero & ~stall;
   end

   assign stall_M     = stall;
   assign dm.dm_req   = req;
   assign dm.dm_we    = ctrl_m.mem_write;
   assign dm.dm_addr  = alu_result_m;
   assign dm.dm_wdata = write_data_m;

   always_comb begin
      ctrl_w_d            = '0;
      ctrl_w_d.valid      = ctrl_m.valid & ~stall;
      ctrl_w_d.reg_write  = ctrl_m.reg_write & ctrl_m.valid & ~stall & ~timeout_hit;
      ctrl_w_d.mem_to_reg = ctrl_m.mem_to_reg;
      ctrl_w_d.err        = timeout_hit;
      ctrl_w_d.rd         = ctrl_m.rd;
      read_data_d         = (req && dm.dm_ack) ? dm.dm_rdata : '0;
      w_d                 = {ctrl_w_d, alu_result_m, read_data_d};
   end

   flopenr #(.W(WW)) u_w_reg (
      .clk   (clk),
      .reset (reset),
      .en    (1'b1),
      .d     (w_d),
      .q     (w_q)
   );

   assign {ctrl_w, aluResult_W, readData_W} = w_q;
   assign valid_W    = ctrl_w.valid;
   assign RegWrite_W = ctrl_w.reg_write;
   assign MemtoReg_W = ctrl_w.mem_to_reg;
   assign err_W      = ctrl_w.err;
   assign rd_W       = ctrl_w.rd;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with TIMEOUT = 4; expected values are hand-computed constants.
module tb_mem_stage;

   localparam int N = 64;

   logic         clk = 1'b0;
   logic         reset;
   logic         valid_E, zero_E, Branch_E, MemRead_E, MemWrite_E, RegWrite_E, MemtoReg_E;
   logic [N-1:0] PCBranch_E, aluResult_E, writeData_E;
   logic [4:0]   rd_E;
   logic         stall_M, PCSrc_M;
   logic [N-1:0] PCBranch_M;
   logic         valid_W, RegWrite_W, MemtoReg_W, err_W;
   logic [N-1:0] aluResult_W, readData_W;
   logic [4:0]   rd_W;

   int tests = 0;
   int fails = 0;

   mem_stage_if #(.N(N)) dm ();

   mem_stage #(.N(N), .TIMEOUT(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .valid_E     (valid_E),
      .PCBranch_E  (PCBranch_E),
      .aluResult_E (aluResult_E),
      .writeData_E (writeData_E),
      .zero_E      (zero_E),
      .Branch_E    (Branch_E),
      .MemRead_E   (MemRead_E),
      .MemWrite_E  (MemWrite_E),
      .RegWrite_E  (RegWrite_E),
      .MemtoReg_E  (MemtoReg_E),
      .rd_E        (rd_E),
      .stall_M     (stall_M),
      .PCSrc_M     (PCSrc_M),
      .PCBranch_M  (PCBranch_M),
      .dm          (dm),
      .valid_W     (valid_W),
      .RegWrite_W  (RegWrite_W),
      .MemtoReg_W  (MemtoReg_W),
      .err_W       (err_W),
      .aluResult_W (aluResult_W),
      .readData_W  (readData_W),
      .rd_W        (rd_W)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_e();
      valid_E = 0; zero_E = 0; Branch_E = 0; MemRead_E = 0; MemWrite_E = 0;
      RegWrite_E = 0; MemtoReg_E = 0; rd_E = '0;
      PCBranch_E = '0; aluResult_E = '0; writeData_E = '0;
   endtask

   initial begin
      reset = 1'b0;
      clr_e();
      dm.dm_ack   = 1'b0;
      dm.dm_rdata = '0;
      tick();
      tick();
      chk("rst_stall", stall_M, 0);
      chk("rst_req", dm.dm_req, 0);
      chk("rst_pcsrc", PCSrc_M, 0);
      chk("rst_valid_w", valid_W, 0);
      chk("rst_err_w", err_W, 0);
      chk("rst_alu_w", aluResult_W, 0);
      reset = 1'b1;

      // plain ALU op
      valid_E = 1; RegWrite_E = 1; aluResult_E = 64'h2A; rd_E = 5'd3;
      #1 chk("alu_stall_e", stall_M, 0);
      tick();
      clr_e();
      #1 chk("alu_stall_m", stall_M, 0);
      chk("alu_req", dm.dm_req, 0);
      tick();
      chk("alu_valid_w", valid_W, 1);
      chk("alu_result_w", aluResult_W, 64'h2A);
      chk("alu_rd_w", rd_W, 3);
      chk("alu_regwrite_w", RegWrite_W, 1);

      // load with same-cycle ack
      valid_E = 1; MemRead_E = 1; MemtoReg_E = 1; RegWrite_E = 1; aluResult_E = 64'h100; rd_E = 5'd5;
      tick();
      clr_e();
      dm.dm_ack = 1; dm.dm_rdata = 64'hDEAD;
      #1 chk("ld0_req", dm.dm_req, 1);
      chk("ld0_addr", dm.dm_addr, 64'h100);
      chk("ld0_we", dm.dm_we, 0);
      chk("ld0_stall", stall_M, 0);
      tick();
      dm.dm_ack = 0; dm.dm_rdata = '0;
      chk("ld0_rdata_w", readData_W, 64'hDEAD);
      chk("ld0_memtoreg_w", MemtoReg_W, 1);
      chk("ld0_valid_w", valid_W, 1);
      chk("ld0_rd_w", rd_W, 5);
      chk("ld0_err_w", err_W, 0);

      // store acked 3 cycles after request
      valid_E = 1; MemWrite_E = 1; aluResult_E = 64'h200; writeData_E = 64'h55AA;
      tick();
      clr_e();
      for (int i = 0; i < 3; i++) begin
         #1 chk("st_stall", stall_M, 1);
         chk("st_we", dm.dm_we, 1);
         chk("st_addr", dm.dm_addr, 64'h200);
         chk("st_wdata", dm.dm_wdata, 64'h55AA);
         if (i > 0) chk("st_bubble", valid_W, 0);
         tick();
      end
      chk("st_bubble3", valid_W, 0);
      dm.dm_ack = 1;
      #1 chk("st_ack_stall", stall_M, 0);
      tick();
      dm.dm_ack = 0;
      chk("st_valid_w", valid_W, 1);
      chk("st_regwrite_w", RegWrite_W, 0);

      // load that never acks, TIMEOUT = 4
      valid_E = 1; MemRead_E = 1; MemtoReg_E = 1; RegWrite_E = 1; aluResult_E = 64'h300; rd_E = 5'd7;
      tick();
      clr_e();
      for (int i = 0; i < 4; i++) begin
         #1 chk("to_stall", stall_M, 1);
         tick();
      end
      chk("to_stall_end", stall_M, 0);
      chk("to_req_last", dm.dm_req, 1);
      tick();
      chk("to_err_w", err_W, 1);
      chk("to_regwrite_w", RegWrite_W, 0);
      chk("to_rdata_w", readData_W, 0);
      chk("to_valid_w", valid_W, 1);
      chk("to_rd_w", rd_W, 7);
      chk("to_req_after", dm.dm_req, 0);
      chk("to_stall_after", stall_M, 0);
      tick();
      chk("to_err_clears", err_W, 0);

      // CBZ taken, followed by an ALU op that must be squashed
      valid_E = 1; Branch_E = 1; zero_E = 1; PCBranch_E = 64'h40;
      tick();
      clr_e();
      valid_E = 1; RegWrite_E = 1; aluResult_E = 64'h77; rd_E = 5'd9;
      #1 chk("br_pcsrc", PCSrc_M, 1);
      chk("br_target", PCBranch_M, 64'h40);
      tick();
      clr_e();
      #1 chk("br_pcsrc_off", PCSrc_M, 0);
      chk("br_valid_w", valid_W, 1);
      tick();
      chk("br_squash_valid_w", valid_W, 0);
      chk("br_squash_regwrite_w", RegWrite_W, 0);

      // CBZ not taken
      valid_E = 1; Branch_E = 1; zero_E = 0; PCBranch_E = 64'h80;
      tick();
      clr_e();
      #1 chk("brnt_pcsrc", PCSrc_M, 0);
      tick();

      // back-to-back loads with same-cycle ack
      dm.dm_ack = 1; dm.dm_rdata = 64'h1111;
      valid_E = 1; MemRead_E = 1; RegWrite_E = 1; MemtoReg_E = 1; aluResult_E = 64'h600; rd_E = 5'd1;
      tick();
      aluResult_E = 64'h608; rd_E = 5'd2;
      #1 chk("b2b_stall0", stall_M, 0);
      chk("b2b_addr0", dm.dm_addr, 64'h600);
      tick();
      clr_e();
      dm.dm_rdata = 64'h2222;
      #1 chk("b2b_stall1", stall_M, 0);
      chk("b2b_addr1", dm.dm_addr, 64'h608);
      chk("b2b_rdata0", readData_W, 64'h1111);
      tick();
      dm.dm_ack = 0; dm.dm_rdata = '0;
      chk("b2b_rdata1", readData_W, 64'h2222);
      chk("b2b_rd1", rd_W, 2);

      // reset in the second wait cycle of a load
      valid_E = 1; MemRead_E = 1; MemtoReg_E = 1; RegWrite_E = 1; aluResult_E = 64'h400; rd_E = 5'd6;
      tick();
      clr_e();
      tick();
      tick();
      #1 chk("rst_wait_stall", stall_M, 1);
      reset = 1'b0;
      tick();
      chk("rstw_req", dm.dm_req, 0);
      chk("rstw_stall", stall_M, 0);
      chk("rstw_pcsrc", PCSrc_M, 0);
      chk("rstw_valid_w", valid_W, 0);
      chk("rstw_regwrite_w", RegWrite_W, 0);
      chk("rstw_memtoreg_w", MemtoReg_W, 0);
      chk("rstw_err_w", err_W, 0);
      chk("rstw_alu_w", aluResult_W, 0);
      chk("rstw_rdata_w", readData_W, 0);
      chk("rstw_rd_w", rd_W, 0);
      reset = 1'b1;
      valid_E = 1; MemRead_E = 1; MemtoReg_E = 1; RegWrite_E = 1; aluResult_E = 64'h500; rd_E = 5'd4;
      tick();
      clr_e();
      #1 chk("rstw_new_req", dm.dm_req, 1);
      chk("rstw_new_addr", dm.dm_addr, 64'h500);
      dm.dm_ack = 1; dm.dm_rdata = 64'hBEEF;
      #1 chk("rstw_new_stall", stall_M, 0);
      tick();
      dm.dm_ack = 0; dm.dm_rdata = '0;
      chk("rstw_new_rdata_w", readData_W, 64'hBEEF);
      chk("rstw_new_valid_w", valid_W, 1);
      chk("rstw_new_err_w", err_W, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
